sr_latch_exerciser: RTL and testbench



---
 rtl/sr_latch_pkg.sv | 25 ++
 rtl/sync2.sv | 21 ++
 rtl/sr_latch_exerciser.sv | 198 +++++++++++++++++++
 tb/tb_sr_latch_exerciser.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr_latch_pkg.sv
// rtl/sr_latch_pkg.sv - shared op encoding, FSM states and expected latch levels
package sr_latch_pkg;

  localparam logic [1:0] OP_SET   = 2'b00;
  localparam logic [1:0] OP_RESET = 2'b01;
  localparam logic [1:0] OP_CHECK = 2'b10;
  localparam logic [1:0] OP_AUTO  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // {q, qb} expected after a clean set or reset pulse
  localparam logic [1:0] EXP_SET   = 2'b10;
  localparam logic [1:0] EXP_RESET = 2'b01;

  function automatic logic [1:0] expect_qqb(input logic set_phase);
    return set_phase ? EXP_SET : EXP_RESET;
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with asynchronous active-low reset
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sr_latch_exerciser.sv
// rtl/sr_latch_exerciser.sv - pulse driver and synchronized checker for the analog SR latch
module sr_latch_exerciser
  import sr_latch_pkg::*;
#(
  parameter int PULSE_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int ITERS         = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [1:0]       op,
  output logic             s_o,
  output logic             r_o,
  input  logic             q_i,
  input  logic             qb_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             q_seen,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             clr_err
);

  localparam int MAXC = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = $clog2(ITERS + 1);

  localparam logic [CW-1:0] PULSE_LOAD  = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0] LAST_ITER   = IW'(ITERS - 1);

  state_t         state, state_nxt;
  logic [1:0]     op_q, op_nxt;
  logic           set_ph, set_ph_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [IW-1:0]  iter, iter_nxt;
  logic           mism, mism_nxt;
  logic           q_sync, qb_sync;
  logic           sample_bad;
  logic           sample_ok_cycle;
  logic           s_nxt, r_nxt, busy_nxt, done_nxt;

  sync2 u_sync_q (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (q_i),
    .q     (q_sync)
  );

  sync2 u_sync_qb (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (qb_i),
    .q     (qb_sync)
  );

  always_comb begin
    sample_bad = 1'b0;
    if (op_q == OP_CHECK) begin
      sample_bad = (q_sync == qb_sync);
    end else begin
      sample_bad = ({q_sync, qb_sync} != expect_qqb(set_ph));
    end
  end

  // A sample only counts when the operation is not being aborted this cycle
  assign sample_ok_cycle = (state == ST_SAMPLE) && ena;

  always_comb begin
    state_nxt  = state;
    op_nxt     = op_q;
    set_ph_nxt = set_ph;
    cnt_nxt    = cnt;
    iter_nxt   = iter;
    mism_nxt   = mism;

    case (state)
      ST_IDLE: begin
        if (ena && start) begin
          op_nxt     = op;
          mism_nxt   = 1'b0;
          iter_nxt   = '0;
          set_ph_nxt = (op != OP_RESET);
          if (op == OP_CHECK) begin
            state_nxt = ST_SETTLE;
            cnt_nxt   = SETTLE_LOAD;
          end else begin
            state_nxt = ST_PULSE;
            cnt_nxt   = PULSE_LOAD;
          end
        end
      end
      ST_PULSE: begin
        if (cnt == '0) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = SETTLE_LOAD;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt == '0) begin
          state_nxt = ST_SAMPLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ST_SAMPLE: begin
        mism_nxt = mism | sample_bad;
        if (op_q == OP_AUTO) begin
          // AUTO runs SET then RESET per pair; the pair closes on the RESET sample
          if (set_ph) begin
            set_ph_nxt = 1'b0;
            state_nxt  = ST_PULSE;
            cnt_nxt    = PULSE_LOAD;
          end else if (iter == LAST_ITER) begin
            state_nxt = ST_DONE;
          end else begin
            iter_nxt   = iter + IW'(1);
            set_ph_nxt = 1'b1;
            state_nxt  = ST_PULSE;
            cnt_nxt    = PULSE_LOAD;
          end
        end else begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (!ena && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
    end
  end

  // Drives are registered from the next state so the latch sees glitch-free pulses
  always_comb begin
    s_nxt    = (state_nxt == ST_PULSE) && set_ph_nxt;
    r_nxt    = (state_nxt == ST_PULSE) && !set_ph_nxt;
    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state_nxt == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op_q   <= OP_SET;
      set_ph <= 1'b0;
      cnt    <= '0;
      iter   <= '0;
      mism   <= 1'b0;
      s_o    <= 1'b0;
      r_o    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      op_q   <= op_nxt;
      set_ph <= set_ph_nxt;
      cnt    <= cnt_nxt;
      iter   <= iter_nxt;
      mism   <= mism_nxt;
      s_o    <= s_nxt;
      r_o    <= r_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      q_seen  <= 1'b0;
      pass    <= 1'b0;
    end else begin
      if (sample_ok_cycle) begin
        q_seen <= q_sync;
        if (sample_bad && (err_cnt != {CNT_W{1'b1}})) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
      end else if ((state == ST_IDLE) && clr_err) begin
        err_cnt <= '0;
      end
      if (state_nxt == ST_DONE) begin
        pass <= !mism_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sr_latch_exerciser.sv
// tb/tb_sr_latch_exerciser.sv - randomized and directed checks against a behavioural latch/op model
module tb_sr_latch_exerciser;
  import sr_latch_pkg::*;

  localparam int P   = 4;
  localparam int S   = 8;
  localparam int IT  = 16;
  localparam int CW  = 8;
  localparam int SAT = 255;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic          clr_err = 1'b0;
  logic          s_o, r_o, busy, done, pass, q_seen;
  logic          q_i, qb_i;
  logic [CW-1:0] err_cnt;

  always #5 clk = ~clk;

  sr_latch_exerciser #(
    .PULSE_CYCLES  (P),
    .SETTLE_CYCLES (S),
    .ITERS         (IT),
    .CNT_W         (CW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .start   (start),
    .op      (op),
    .s_o     (s_o),
    .r_o     (r_o),
    .q_i     (q_i),
    .qb_i    (qb_i),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .q_seen  (q_seen),
    .err_cnt (err_cnt),
    .clr_err (clr_err)
  );

  // Analog latch stand-in: fault 0 healthy, 1 stuck q=0/qb=1, 2 both outputs high
  logic lq = 1'b0;
  int   fault = 0;

  always @(s_o or r_o) begin
    if (s_o) lq = 1'b1;
    else if (r_o) lq = 1'b0;
  end

  assign q_i  = (fault == 0) ? lq  : (fault == 2);
  assign qb_i = (fault == 0) ? ~lq : 1'b1;

  int   vectors = 0;
  int   miscompares = 0;
  int   ref_err = 0;
  logic ref_q = 1'b0;
  logic ref_pass = 1'b0;
  logic ref_qseen = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) check("no_overlap", {31'd0, s_o & r_o}, 32'd0);
  end

  function automatic int mism_for(input int f, input logic [1:0] o);
    if (f == 0) return 0;
    if (f == 1) return (o == OP_SET) ? 1 : ((o == OP_AUTO) ? IT : 0);
    return (o == OP_AUTO) ? 2 * IT : 1;
  endfunction

  function automatic int latency(input logic [1:0] o);
    if (o == OP_CHECK) return S + 2;
    if (o == OP_AUTO) return 1 + 2 * IT * (P + S + 1);
    return P + S + 2;
  endfunction

  task automatic run_op(input logic [1:0] o, input bit poke);
    int exp_m;
    int lat;
    int seen;
    exp_m = mism_for(fault, o);
    lat   = latency(o);
    seen  = 0;
    @(negedge clk);
    op = o;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= lat + 5 && seen == 0; c++) begin
      @(negedge clk);
      start   = poke && (c == 3);
      clr_err = poke && (c == 3);
      if (o == OP_SET || o == OP_RESET) begin
        check("s_drive", s_o, (o == OP_SET) && (c <= P));
        check("r_drive", r_o, (o == OP_RESET) && (c <= P));
      end
      if (done) seen = c;
      else check("busy_during_op", busy, 1);
    end
    start = 1'b0;
    clr_err = 1'b0;
    ref_err  = (ref_err + exp_m > SAT) ? SAT : ref_err + exp_m;
    ref_pass = (exp_m == 0);
    if (o == OP_SET) ref_q = 1'b1;
    else if (o == OP_RESET || o == OP_AUTO) ref_q = 1'b0;
    ref_qseen = (fault == 0) ? ref_q : (fault == 2);
    check("latency", seen, lat);
    check("busy_at_done", busy, 1);
    check("pass", pass, ref_pass);
    check("q_seen", q_seen, ref_qseen);
    check("err_cnt", err_cnt, ref_err);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    logic [1:0] o;
    #1;
    check("rst_s_o", s_o, 0);
    check("rst_r_o", r_o, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_q_seen", q_seen, 0);
    check("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ena = 1'b1;

    fault = 0;
    run_op(OP_SET, 1'b0);

    fault = 1;
    run_op(OP_AUTO, 1'b0);

    fault = 2;
    run_op(OP_CHECK, 1'b1);

    for (int i = 0; i < 24; i++) begin
      fault = $urandom_range(0, 2);
      o = 2'($urandom_range(0, 3));
      if (o == OP_AUTO && $urandom_range(0, 2) != 0) o = 2'($urandom_range(0, 2));
      run_op(o, $urandom_range(0, 3) == 0);
    end

    fault = 1;
    for (int i = 0; i < 17; i++) run_op(OP_AUTO, 1'b0);
    check("saturated", err_cnt, SAT);

    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    ref_err = 0;
    @(negedge clk);
    check("clr_idle", err_cnt, 0);

    fault = 2;
    run_op(OP_SET, 1'b0);

    fault = 0;
    @(negedge clk);
    op = OP_RESET;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("abort_r_before", r_o, 1);
    @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    check("abort_r_o", r_o, 0);
    check("abort_busy", busy, 0);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    check("abort_err", err_cnt, ref_err);
    check("abort_pass", pass, ref_pass);
    ena = 1'b1;
    ref_q = 1'b0;
    run_op(OP_SET, 1'b0);

    fault = 2;
    run_op(OP_RESET, 1'b0);
    @(negedge clk);
    op = OP_SET;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= P + 3; c++) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_s_o", s_o, 0);
    check("arst_r_o", r_o, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_err_cnt", err_cnt, 0);
    check("arst_pass", pass, 0);
    ref_q = 1'b1;
    ref_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(OP_CHECK, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
